packet_scheduler: RTL and testbench
===================================

# packet_scheduler

Selects which HDMI data-island packet the packet assembler transmits in each 32-pixel packet slot, arbitrating between buffered audio samples, Audio Clock Regeneration (ACR), AVI InfoFrame and Audio InfoFrame requests, and falling back to NULL packets. It sits in the `clk_pixel` domain between the audio/timing sources and the packet assembler inside `hdmi`. It also owns the 192-frame IEC 60958 channel-status frame counter that drives the audio-sample B flag.

## Interface
- `AUDIO_BIT_WIDTH`, 24: bits per channel sample.
- `AUDIO_FIFO_DEPTH`, 4: sample FIFO entries; must be a power of 2 and at least 2.
- `clk_pixel`  in  1  pixel clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `video_field_end`  in  1  one-cycle pulse on the last pixel of a frame; arms both InfoFrames.
- `acr_tick`  in  1  one-cycle pulse from the clock-regeneration counter; arms ACR.
- `packet_slot`  in  1  one-cycle pulse when the assembler latches the current selection.
- `audio_sample_word`  in  2*AUDIO_BIT_WIDTH  sample word, `{right, left}`.
- `audio_sample_valid`  in  1  sample offered.
- `audio_sample_ready`  out  1  FIFO can accept a sample.
- `packet_type`  out  8  selected type: 8'h00 NULL, 8'h01 ACR, 8'h02 sample, 8'h82 AVI, 8'h84 Audio InfoFrame.
- `sample_word_out`  out  2*AUDIO_BIT_WIDTH  sample for type 8'h02; otherwise 0.
- `sample_frame_start`  out  1  B flag: 1 iff type is 8'h02 and `sample_index` is 0.
- `sample_index`  out  8  channel-status bit index, 0..191, of the presented sample.
- `sample_overflow`  out  1  sticky; set when a sample is offered while `audio_sample_ready` is 0.

## Operation
- **Pending flags.** Three flags: `acr_pend`, `avi_pend` and `aif_pend`.
  - `acr_tick` sets `acr_pend`; `video_field_end` sets `avi_pend` and `aif_pend`.
  - A flag clears when its type is consumed. If a set and a clear land in the same cycle, the set wins.
  - Re-arming a flag that is already set is idempotent: no counting, no error.
- **Audio FIFO.** `audio_sample_ready` = count < `AUDIO_FIFO_DEPTH`, computed from the registered count.
  - A push occurs on valid && ready.
  - valid && !ready drops the sample and sets `sample_overflow`. This holds even if a pop occurs in the same cycle.
- **Selection register.** Holds `packet_type`, `sample_word_out`, `sample_index` and `sample_frame_start`.
- **Consume.** On `packet_slot`, the presented selection is consumed:
  - 8'h02: pop the FIFO; `sample_index` advances, wrapping 191 -> 0.
  - 8'h01, 8'h82 or 8'h84: clear the matching flag.
  - 8'h00: no side effect.
- **Next selection.** In the same `packet_slot` edge, the next selection is chosen by fixed priority, using registered state after this consume:
  1. sample, if the FIFO still holds at least one entry after the pop;
  2. ACR, if pending and not just consumed;
  3. AVI, same condition;
  4. Audio InfoFrame, same condition;
  5. otherwise NULL.
- **Hold.** Between `packet_slot` pulses the selection is held stable.
  - A request arriving mid-slot is not presented until the next `packet_slot`.
  - Exception: when the held selection is NULL and any source becomes eligible, the selection is upgraded on the next edge. This is allowed because NULL has not yet been committed.
- **Reset.** Reset at any time empties the FIFO, clears all flags and `sample_overflow`, sets `sample_index` to 0, and sets `packet_type` to 8'h00 with every other output 0. `audio_sample_ready` is 1 once reset deasserts.

## Timing
- Sample push at edge t can be presented at t+1 if the current selection is NULL; otherwise it is presented at the first `packet_slot` after t.
- Selection outputs are registered; no combinational path from any input to `packet_type`.
- `audio_sample_ready` is combinational from the registered count only.
- `packet_slot` is asserted at most once per 32 cycles; the block must still behave correctly if it is asserted on consecutive cycles.
- Simultaneous `packet_slot`, push and `acr_tick`: pop and push both apply; count is unchanged; `acr_pend` ends set.

## Structure
- `hdmi_packet_pkg` holds the packet-type localparams (`PKT_NULL`, `PKT_ACR`, `PKT_SAMPLE`, `PKT_AVI_IF`, `PKT_AUDIO_IF`) and the constant `IEC_FRAMES` = 192. It is shared with the packet assembler and the bench.
- Sub-module `audio_sample_fifo`: synchronous FIFO with an asynchronous reset, sized by `AUDIO_FIFO_DEPTH` and `2*AUDIO_BIT_WIDTH`.

## Test plan
- **Reset state.** Reset asserted mid-slot with a full FIFO and all flags set -> next cycle `packet_type`=8'h00, `audio_sample_ready`=1, `sample_index`=0, `sample_overflow`=0.
- **Priority order.** One sample pushed, plus `acr_tick` and `video_field_end` in the same cycle, then five `packet_slot` pulses 32 cycles apart -> types consumed in order 02, 01, 82, 84, 00.
- **Overflow.** Push 5 samples back-to-back with no `packet_slot` and depth 4 -> the 5th is dropped, `sample_overflow`=1, `audio_sample_ready`=0. The four samples then appear in FIFO order.
- **Channel-status wrap.** Consume 193 samples -> `sample_frame_start`=1 on samples #1 and #193, 0 on all others; `sample_index` reads 191 on sample #192.
- **Set/clear collision.** `acr_tick` on the same edge as `packet_slot` consuming ACR -> ACR is presented again in the following slot.
- **NULL upgrade.** FIFO empty and NULL presented, then push at cycle 5 of the slot -> `packet_type`=8'h02 at cycle 6; the sample is consumed at the next `packet_slot`.

Source files
------------

// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island packet definitions: packet type codes and the
// IEC 60958 channel-status block length.
package hdmi_packet_pkg;

  localparam logic [7:0] PKT_NULL     = 8'h00;
  localparam logic [7:0] PKT_ACR      = 8'h01;
  localparam logic [7:0] PKT_SAMPLE   = 8'h02;
  localparam logic [7:0] PKT_AVI_IF   = 8'h82;
  localparam logic [7:0] PKT_AUDIO_IF = 8'h84;

  localparam int unsigned IEC_FRAMES = 192;

  // Next channel-status bit index, wrapping at the end of the 192-frame block.
  function automatic logic [7:0] iec_next(input logic [7:0] idx);
    return (idx == 8'(IEC_FRAMES - 1)) ? 8'd0 : idx + 8'd1;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with asynchronous reset. Exposes the head entry and
// the entry behind it so the scheduler can select the post-pop head in the
// same cycle it pops.
module audio_sample_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head_data,
  output logic [WIDTH-1:0]           next_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head_data = mem[rd_ptr];
  assign next_data = mem[rd_ptr + AW'(1)];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; push and pop in one cycle leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

endmodule

// File: rtl/packet_scheduler.sv
// Per-slot packet selection for the HDMI data island: buffered audio samples
// first, then ACR, AVI and Audio InfoFrames, else NULL. Also tracks the
// 192-frame channel-status index that produces the audio B flag.
module packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int unsigned AUDIO_BIT_WIDTH  = 24,
  parameter int unsigned AUDIO_FIFO_DEPTH = 4
) (
  input  logic                         clk_pixel,
  input  logic                         reset,
  input  logic                         video_field_end,
  input  logic                         acr_tick,
  input  logic                         packet_slot,
  input  logic [2*AUDIO_BIT_WIDTH-1:0] audio_sample_word,
  input  logic                         audio_sample_valid,
  output logic                         audio_sample_ready,
  output logic [7:0]                   packet_type,
  output logic [2*AUDIO_BIT_WIDTH-1:0] sample_word_out,
  output logic                         sample_frame_start,
  output logic [7:0]                   sample_index,
  output logic                         sample_overflow
);

  localparam int unsigned SW = 2 * AUDIO_BIT_WIDTH;
  localparam int unsigned CW = $clog2(AUDIO_FIFO_DEPTH) + 1;

  logic [CW-1:0] fifo_count;
  logic [SW-1:0] fifo_head;
  logic [SW-1:0] fifo_next;
  logic          push;
  logic          pop;
  logic          acr_pend, avi_pend, aif_pend;
  logic          clr_acr, clr_avi, clr_aif;
  logic          reload;
  logic [CW-1:0] count_after;
  logic [7:0]    idx_after;
  logic [7:0]    cand_type;
  logic [SW-1:0] cand_word;

  assign audio_sample_ready = (fifo_count < CW'(AUDIO_FIFO_DEPTH));
  assign push = audio_sample_valid && audio_sample_ready;
  assign pop  = packet_slot && (packet_type == PKT_SAMPLE);

  assign clr_acr = packet_slot && (packet_type == PKT_ACR);
  assign clr_avi = packet_slot && (packet_type == PKT_AVI_IF);
  assign clr_aif = packet_slot && (packet_type == PKT_AUDIO_IF);

  // A held NULL is not yet committed, so it may be replaced on any edge.
  assign reload = packet_slot || (packet_type == PKT_NULL);

  audio_sample_fifo #(
    .DEPTH (AUDIO_FIFO_DEPTH),
    .WIDTH (SW)
  ) u_fifo (
    .clk       (clk_pixel),
    .rst       (reset),
    .push      (push),
    .pop       (pop),
    .wr_data   (audio_sample_word),
    .count     (fifo_count),
    .head_data (fifo_head),
    .next_data (fifo_next)
  );

  // Next selection by fixed priority from registered state after this consume.
  // A sample pushed on this same edge is not counted yet.
  always_comb begin
    count_after = fifo_count - CW'(pop);
    idx_after   = pop ? iec_next(sample_index) : sample_index;
    cand_type   = PKT_NULL;
    cand_word   = '0;
    if (count_after != '0) begin
      cand_type = PKT_SAMPLE;
      cand_word = pop ? fifo_next : fifo_head;
    end else if (acr_pend && !clr_acr) begin
      cand_type = PKT_ACR;
    end else if (avi_pend && !clr_avi) begin
      cand_type = PKT_AVI_IF;
    end else if (aif_pend && !clr_aif) begin
      cand_type = PKT_AUDIO_IF;
    end
  end

  // Pending flags (set beats clear), sticky overflow and the selection register.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      acr_pend           <= 1'b0;
      avi_pend           <= 1'b0;
      aif_pend           <= 1'b0;
      sample_overflow    <= 1'b0;
      packet_type        <= PKT_NULL;
      sample_word_out    <= '0;
      sample_index       <= '0;
      sample_frame_start <= 1'b0;
    end else begin
      acr_pend <= acr_tick        || (acr_pend && !clr_acr);
      avi_pend <= video_field_end || (avi_pend && !clr_avi);
      aif_pend <= video_field_end || (aif_pend && !clr_aif);
      if (audio_sample_valid && !audio_sample_ready) sample_overflow <= 1'b1;
      if (reload) begin
        packet_type        <= cand_type;
        sample_word_out    <= cand_word;
        sample_index       <= idx_after;
        sample_frame_start <= (cand_type == PKT_SAMPLE) && (idx_after == 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_packet_scheduler.sv
// Self-checking bench for packet_scheduler: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_packet_scheduler;
  import hdmi_packet_pkg::*;

  localparam int unsigned BW    = 24;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SW    = 2 * BW;

  logic          clk_pixel = 1'b0;
  logic          reset = 1'b1;
  logic          video_field_end = 1'b0;
  logic          acr_tick = 1'b0;
  logic          packet_slot = 1'b0;
  logic [SW-1:0] audio_sample_word = '0;
  logic          audio_sample_valid = 1'b0;
  logic          audio_sample_ready;
  logic [7:0]    packet_type;
  logic [SW-1:0] sample_word_out;
  logic          sample_frame_start;
  logic [7:0]    sample_index;
  logic          sample_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [SW-1:0] mq[$];
  bit            m_acr, m_avi, m_aif, m_ovf;
  logic [7:0]    m_type;
  logic [SW-1:0] m_word;
  int            m_idx;      // samples consumed, modulo 192
  int            m_sel_idx;  // index of the presented sample

  packet_scheduler #(
    .AUDIO_BIT_WIDTH  (BW),
    .AUDIO_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .video_field_end    (video_field_end),
    .acr_tick           (acr_tick),
    .packet_slot        (packet_slot),
    .audio_sample_word  (audio_sample_word),
    .audio_sample_valid (audio_sample_valid),
    .audio_sample_ready (audio_sample_ready),
    .packet_type        (packet_type),
    .sample_word_out    (sample_word_out),
    .sample_frame_start (sample_frame_start),
    .sample_index       (sample_index),
    .sample_overflow    (sample_overflow)
  );

  always #5 clk_pixel = ~clk_pixel;

  function automatic logic [SW-1:0] rand_word();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_acr = 0; m_avi = 0; m_aif = 0; m_ovf = 0;
    m_type = PKT_NULL; m_word = '0; m_idx = 0; m_sel_idx = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [SW-1:0] q[$];
    logic [7:0]    consumed;
    bit            do_push;
    q = mq;
    do_push = audio_sample_valid && (q.size() < DEPTH);
    if (audio_sample_valid && q.size() >= DEPTH) m_ovf = 1;
    consumed = packet_slot ? m_type : 8'hFF;
    if (consumed == PKT_SAMPLE) begin
      void'(q.pop_front());
      m_idx = (m_idx + 1) % IEC_FRAMES;
    end
    if (packet_slot || m_type == PKT_NULL) begin
      m_word = '0;
      if (q.size() > 0) begin
        m_type = PKT_SAMPLE; m_word = q[0]; m_sel_idx = m_idx;
      end else if (m_acr && consumed != PKT_ACR)      m_type = PKT_ACR;
      else if (m_avi && consumed != PKT_AVI_IF)       m_type = PKT_AVI_IF;
      else if (m_aif && consumed != PKT_AUDIO_IF)     m_type = PKT_AUDIO_IF;
      else                                            m_type = PKT_NULL;
    end
    m_acr = acr_tick        || (m_acr && consumed != PKT_ACR);
    m_avi = video_field_end || (m_avi && consumed != PKT_AVI_IF);
    m_aif = video_field_end || (m_aif && consumed != PKT_AUDIO_IF);
    if (do_push) q.push_back(audio_sample_word);
    mq = q;
  endtask

  // One clock with the inputs set by the caller; pulses then drop to 0.
  task automatic tick();
    model_edge();
    @(posedge clk_pixel);
    #1;
    video_field_end = 0; acr_tick = 0; packet_slot = 0;
    audio_sample_valid = 0; audio_sample_word = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    @(posedge clk_pixel); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      audio_sample_valid = 1; audio_sample_word = rand_word();
      if (i == 0) begin acr_tick = 1; video_field_end = 1; end
      tick();
    end
    #2 reset = 1;
    model_reset();
    #1;
    checks++; if (packet_type !== PKT_NULL) begin errors++; $display("FAIL reset_type got %h want %h", packet_type, PKT_NULL); end
    checks++; if (sample_index !== 8'd0) begin errors++; $display("FAIL reset_index got %0d want 0", sample_index); end
    checks++; if (sample_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", sample_overflow); end
    checks++; if (sample_word_out !== '0 || sample_frame_start !== 1'b0) begin errors++; $display("FAIL reset_outputs word %h fs %b want 0", sample_word_out, sample_frame_start); end
    @(posedge clk_pixel); #1;
    reset = 0;
    #1;
    checks++; if (audio_sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", audio_sample_ready); end
    // flags must be clear: nothing should be presented even after upgrades
    tick(); tick();
    checks++; if (packet_type !== PKT_NULL) begin errors++; $display("FAIL reset_flags_clear got %h want %h", packet_type, PKT_NULL); end
  endtask

  task automatic test_priority();
    logic [7:0] exp_order [5] = '{PKT_SAMPLE, PKT_ACR, PKT_AVI_IF, PKT_AUDIO_IF, PKT_NULL};
    audio_sample_valid = 1; audio_sample_word = rand_word();
    acr_tick = 1; video_field_end = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 31; c++) tick();
      checks++;
      if (packet_type !== exp_order[k] || packet_type !== m_type) begin
        errors++; $display("FAIL priority_%0d got %h want %h", k, packet_type, exp_order[k]);
      end
      packet_slot = 1;
      tick();
    end
  endtask

  task automatic test_overflow();
    logic [SW-1:0] words[5];
    for (int i = 0; i < 5; i++) begin
      words[i] = rand_word();
      audio_sample_valid = 1; audio_sample_word = words[i];
      tick();
    end
    checks++; if (sample_overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag got %b want 1", sample_overflow); end
    checks++; if (audio_sample_ready !== 1'b0) begin errors++; $display("FAIL overflow_ready got %b want 0", audio_sample_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (packet_type !== PKT_SAMPLE || sample_word_out !== words[i]) begin
        errors++; $display("FAIL overflow_order_%0d got %h/%h want %h/%h", i, packet_type, sample_word_out, PKT_SAMPLE, words[i]);
      end
      packet_slot = 1;
      tick();
    end
    checks++; if (packet_type !== PKT_NULL) begin errors++; $display("FAIL overflow_drained got %h want 00", packet_type); end
  endtask

  task automatic test_null_upgrade();
    packet_slot = 1; tick();
    for (int c = 1; c < 5; c++) tick();
    checks++; if (packet_type !== PKT_NULL) begin errors++; $display("FAIL upgrade_idle got %h want 00", packet_type); end
    audio_sample_valid = 1; audio_sample_word = rand_word();
    tick();   // push at cycle 5
    tick();   // cycle 6
    checks++; if (packet_type !== PKT_SAMPLE || sample_word_out !== m_word) begin errors++; $display("FAIL upgrade_present got %h/%h want 02/%h", packet_type, sample_word_out, m_word); end
    for (int c = 6; c < 31; c++) tick();
    packet_slot = 1; tick();
    checks++; if (packet_type !== PKT_NULL) begin errors++; $display("FAIL upgrade_consumed got %h want 00", packet_type); end
  endtask

  task automatic test_collision();
    bit seen;
    acr_tick = 1; tick();
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      if (packet_type === PKT_ACR) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL collision_first_acr got %h want 01 within 8 cycles", packet_type); end
    packet_slot = 1; acr_tick = 1; tick();
    checks++; if (packet_type !== m_type) begin errors++; $display("FAIL collision_after got %h want %h", packet_type, m_type); end
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (packet_type === PKT_ACR) seen = 1; else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL collision_rearmed got %h want 01 within 8 cycles", packet_type); end
    packet_slot = 1; tick(); tick();
    checks++; if (packet_type !== PKT_NULL) begin errors++; $display("FAIL collision_cleared got %h want 00", packet_type); end
  endtask

  task automatic test_cs_wrap();
    do_reset();
    for (int n = 1; n <= 193; n++) begin
      audio_sample_valid = 1; audio_sample_word = rand_word();
      tick(); tick();
      checks++;
      if (packet_type !== PKT_SAMPLE || sample_word_out !== m_word) begin
        errors++; $display("FAIL cs_sample_%0d got %h/%h want 02/%h", n, packet_type, sample_word_out, m_word);
      end
      checks++;
      if (sample_frame_start !== ((n == 1 || n == 193) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL cs_bflag_%0d got %b want %b", n, sample_frame_start, (n == 1 || n == 193));
      end
      checks++;
      if (sample_index !== 8'((n - 1) % 192)) begin
        errors++; $display("FAIL cs_index_%0d got %0d want %0d", n, sample_index, (n - 1) % 192);
      end
      packet_slot = 1; tick();
    end
  endtask

  task automatic test_random();
    int gap = 0;
    for (int c = 0; c < 3000; c++) begin
      audio_sample_valid = ($urandom_range(0, 1) == 1);
      audio_sample_word  = rand_word();
      acr_tick           = ($urandom_range(0, 19) == 0);
      video_field_end    = ($urandom_range(0, 39) == 0);
      packet_slot        = (gap > 0 && $urandom_range(0, 7) == 0) || ($urandom_range(0, 63) == 0);
      gap = packet_slot ? 0 : gap + 1;
      tick();
      checks++;
      if (packet_type !== m_type || sample_word_out !== m_word) begin
        errors++; $display("FAIL rand_sel cyc %0d got %h/%h want %h/%h", c, packet_type, sample_word_out, m_type, m_word);
      end
      checks++;
      if (audio_sample_ready !== (mq.size() < DEPTH) || sample_overflow !== m_ovf) begin
        errors++; $display("FAIL rand_fifo cyc %0d got rdy %b ovf %b want %b %b", c, audio_sample_ready, sample_overflow, mq.size() < DEPTH, m_ovf);
      end
      if (m_type == PKT_SAMPLE) begin
        checks++;
        if (sample_index !== 8'(m_sel_idx) || sample_frame_start !== (m_sel_idx == 0)) begin
          errors++; $display("FAIL rand_cs cyc %0d got %0d/%b want %0d/%b", c, sample_index, sample_frame_start, m_sel_idx, m_sel_idx == 0);
        end
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_priority();
    test_overflow();
    test_null_upgrade();
    test_collision();
    test_cs_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
